pet_status_fsm: RTL and testbench

Downstream consumer of the six 4-bit pet statistics (hunger, happiness, health, hygiene, energy, social). Samples them on a slow evaluation tick and runs the pet's life-state machine: OK, NEEDY, SLEEPY, SICK, DEAD. Drives the display/sprite selector and the buzzer: current state, the worst need, an attention level and a one-cycle alarm pulse. Also keeps an age counter.

---
 rtl/pet_pkg.sv | 29 ++
 rtl/pet_need_max.sv | 45 ++++
 rtl/pet_status_fsm.sv | 160 ++++++++++++++++
 tb/tb_pet_status_fsm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// pet_pkg: shared types and constants for the pet life-state logic.
//   pet_state_e : life states, encoded as they appear on the state output
//   NEED_*      : need_id codes (4 is energy, which never wins the need race)
//   DEF_*       : default thresholds and timing
package pet_pkg;

  typedef enum logic [2:0] {
    ST_OK     = 3'd0,
    ST_NEEDY  = 3'd1,
    ST_SLEEPY = 3'd2,
    ST_SICK   = 3'd3,
    ST_DEAD   = 3'd4
  } pet_state_e;

  localparam logic [2:0] NEED_HUNGER    = 3'd0;
  localparam logic [2:0] NEED_HAPPINESS = 3'd1;
  localparam logic [2:0] NEED_HEALTH    = 3'd2;
  localparam logic [2:0] NEED_HYGIENE   = 3'd3;
  localparam logic [2:0] NEED_SOCIAL    = 3'd5;
  localparam logic [2:0] NEED_NONE      = 3'd7;

  localparam int DEF_TICK_DIV    = 1000;
  localparam int DEF_WARN_LEVEL  = 8;
  localparam int DEF_CRIT_LEVEL  = 12;
  localparam int DEF_SLEEP_LEVEL = 2;
  localparam int DEF_SICK_TICKS  = 16;
  localparam int DEF_DEATH_TICKS = 32;

endpackage

// File: rtl/pet_need_max.sv
// pet_need_max: combinational maximum over the five need statistics.
// Ports:
//   hunger, happiness, health, hygiene, social : 4-bit need levels
//   worst    : largest of the five levels
//   worst_id : need_id code of the largest; ties resolve to the lowest code
module pet_need_max
  import pet_pkg::*;
(
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] social,
  output logic [3:0] worst,
  output logic [2:0] worst_id
);

  logic [3:0] vals [5];
  logic [2:0] ids  [5];

  assign vals[0] = hunger;
  assign vals[1] = happiness;
  assign vals[2] = health;
  assign vals[3] = hygiene;
  assign vals[4] = social;

  assign ids[0] = NEED_HUNGER;
  assign ids[1] = NEED_HAPPINESS;
  assign ids[2] = NEED_HEALTH;
  assign ids[3] = NEED_HYGIENE;
  assign ids[4] = NEED_SOCIAL;

  // Scan in ascending code order; strict '>' keeps the earliest of equal values.
  always_comb begin
    worst    = vals[0];
    worst_id = ids[0];
    for (int i = 1; i < 5; i++) begin
      if (vals[i] > worst) begin
        worst    = vals[i];
        worst_id = ids[i];
      end
    end
  end

endmodule

// File: rtl/pet_status_fsm.sv
// pet_status_fsm: samples the pet statistics on a slow evaluation tick and
// runs the life-state machine (OK, NEEDY, SLEEPY, SICK, DEAD).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   hunger..social      : 4-bit statistics (energy: lower is sleepier)
//   revive              : restart request, only acted on while DEAD
//   state               : current life state (pet_state_e encoding)
//   need_id             : worst need code, 7 when nothing is at warning level
//   attention           : high while NEEDY or SICK
//   alarm               : one-cycle pulse on entry to SICK or DEAD
//   age                 : evaluation ticks survived, saturating at 255
module pet_status_fsm
  import pet_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int WARN_LEVEL  = DEF_WARN_LEVEL,
  parameter int CRIT_LEVEL  = DEF_CRIT_LEVEL,
  parameter int SLEEP_LEVEL = DEF_SLEEP_LEVEL,
  parameter int SICK_TICKS  = DEF_SICK_TICKS,
  parameter int DEATH_TICKS = DEF_DEATH_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  input  logic       revive,
  output logic [2:0] state,
  output logic [2:0] need_id,
  output logic       attention,
  output logic       alarm,
  output logic [7:0] age
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  pet_state_e    state_q, state_d;
  logic [4:0]    crit_cnt_q, crit_cnt_d;
  logic [5:0]    death_cnt_q, death_cnt_d;
  logic [2:0]    need_id_q, need_id_d;
  logic [7:0]    age_q, age_d;
  logic          alarm_q, alarm_d;
  logic          attention_q, attention_d;

  logic [3:0]    worst;
  logic [2:0]    worst_id;
  logic          warn, crit, sleepy;
  logic [5:0]    crit_inc;
  logic [6:0]    death_inc;

  pet_need_max u_need_max (
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .social    (social),
    .worst     (worst),
    .worst_id  (worst_id)
  );

  assign tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  assign warn   = (worst >= 4'(WARN_LEVEL));
  assign crit   = (worst >= 4'(CRIT_LEVEL));
  assign sleepy = (energy <= 4'(SLEEP_LEVEL));

  // Widened so the threshold compares cannot alias on counter wrap.
  assign crit_inc  = {1'b0, crit_cnt_q} + 6'd1;
  assign death_inc = {1'b0, death_cnt_q} + 7'd1;

  always_comb begin
    state_d     = state_q;
    crit_cnt_d  = crit_cnt_q;
    death_cnt_d = death_cnt_q;
    need_id_d   = need_id_q;
    age_d       = age_q;
    alarm_d     = 1'b0;

    if (state_q == ST_DEAD) begin
      // Ticks are ignored here; only revive moves the machine.
      if (revive) begin
        state_d     = ST_OK;
        crit_cnt_d  = '0;
        death_cnt_d = '0;
        age_d       = '0;
        need_id_d   = NEED_NONE;
      end
    end else if (tick) begin
      if (age_q != 8'hFF) age_d = age_q + 8'd1;
      need_id_d = warn ? worst_id : NEED_NONE;
      if (!crit)                    crit_cnt_d = '0;
      else if (crit_cnt_q != 5'h1F) crit_cnt_d = crit_cnt_q + 5'd1;

      case (state_q)
        ST_SICK: begin
          if (crit) begin
            death_cnt_d = death_inc[5:0];
            if (death_inc == 7'(DEATH_TICKS)) begin
              state_d = ST_DEAD;
              alarm_d = 1'b1;
            end
          end else begin
            death_cnt_d = '0;
            if (!warn) state_d = sleepy ? ST_SLEEPY : ST_OK;
          end
        end
        default: begin
          if (crit && (crit_inc == 6'(SICK_TICKS))) begin
            state_d     = ST_SICK;
            death_cnt_d = '0;
            alarm_d     = 1'b1;
          end else if (sleepy) begin
            state_d = ST_SLEEPY;
          end else if (warn) begin
            state_d = ST_NEEDY;
          end else begin
            state_d = ST_OK;
          end
        end
      endcase
    end

    attention_d = (state_d == ST_NEEDY) || (state_d == ST_SICK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      state_q     <= ST_OK;
      crit_cnt_q  <= '0;
      death_cnt_q <= '0;
      need_id_q   <= NEED_NONE;
      age_q       <= '0;
      alarm_q     <= 1'b0;
      attention_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      crit_cnt_q  <= crit_cnt_d;
      death_cnt_q <= death_cnt_d;
      need_id_q   <= need_id_d;
      age_q       <= age_d;
      alarm_q     <= alarm_d;
      attention_q <= attention_d;
    end
  end

  assign state     = state_q;
  assign need_id   = need_id_q;
  assign attention = attention_q;
  assign alarm     = alarm_q;
  assign age       = age_q;

endmodule

// File: tb/tb_pet_status_fsm.sv
module tb_pet_status_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hunger = 4'd0, happiness = 4'd0, health = 4'd0;
  logic [3:0] hygiene = 4'd0, energy = 4'd10, social = 4'd0;
  logic       revive = 1'b0;
  logic [2:0] state, need_id;
  logic       attention, alarm;
  logic [7:0] age;

  int n_checks = 0;
  int n_fail   = 0;
  int alarm_cnt = 0;
  logic prev_alarm = 1'b0;

  pet_status_fsm #(
    .TICK_DIV    (4),
    .SICK_TICKS  (3),
    .DEATH_TICKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .energy    (energy),
    .social    (social),
    .revive    (revive),
    .state     (state),
    .need_id   (need_id),
    .attention (attention),
    .alarm     (alarm),
    .age       (age)
  );

  always #5 clk = ~clk;

  // One clock edge, sampled 1 time unit later; tracks alarm pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (alarm) alarm_cnt++;
    n_checks++;
    if (alarm && prev_alarm) begin
      n_fail++;
      $display("FAIL alarm_consecutive: alarm=1 on two consecutive cycles, required single-cycle pulse");
    end
    prev_alarm = alarm;
  endtask

  task automatic run_ticks(input int n);
    repeat (4 * n) step();
  endtask

  task automatic set_stats(input logic [3:0] hu, ha, he, hy, en, so);
    hunger = hu; happiness = ha; health = he; hygiene = hy; energy = en; social = so;
  endtask

  // Leaves the bench aligned so that each run_ticks(1) ends just after a tick edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    alarm_cnt  = 0;
    prev_alarm = 1'b0;
  endtask

  task automatic test_reset();
    set_stats(4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0);
    apply_reset();
    $display("test_reset: state=%0d need_id=%0d attention=%0b alarm=%0b age=%0d", state, need_id, attention, alarm, age);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state); end
    n_checks++; if (need_id !== 3'd7)   begin n_fail++; $display("FAIL reset_need_id: got %0d, required 7", need_id); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL reset_attention: got %0b, required 0", attention); end
    n_checks++; if (alarm !== 1'b0)     begin n_fail++; $display("FAIL reset_alarm: got %0b, required 0", alarm); end
    n_checks++; if (age !== 8'd0)       begin n_fail++; $display("FAIL reset_age: got %0d, required 0", age); end
  endtask

  task automatic test_ok_idle();
    apply_reset();
    set_stats(4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0);
    run_ticks(10);
    $display("test_ok_idle: state=%0d need_id=%0d attention=%0b age=%0d", state, need_id, attention, age);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL ok_state: got %0d, required 0", state); end
    n_checks++; if (need_id !== 3'd7)   begin n_fail++; $display("FAIL ok_need_id: got %0d, required 7", need_id); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL ok_attention: got %0b, required 0", attention); end
    n_checks++; if (age !== 8'd10)      begin n_fail++; $display("FAIL ok_age: got %0d, required 10", age); end
  endtask

  task automatic test_needy_tie();
    apply_reset();
    set_stats(4'd9, 4'd0, 4'd0, 4'd0, 4'd10, 4'd9);
    run_ticks(1);
    $display("test_needy_tie: state=%0d need_id=%0d attention=%0b age=%0d", state, need_id, attention, age);
    n_checks++; if (state !== 3'd1)     begin n_fail++; $display("FAIL needy_state: got %0d, required 1", state); end
    n_checks++; if (need_id !== 3'd0)   begin n_fail++; $display("FAIL needy_tie_id: got %0d, required 0", need_id); end
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL needy_attention: got %0b, required 1", attention); end
    // social alone is worst: code 5
    set_stats(4'd3, 4'd0, 4'd0, 4'd0, 4'd10, 4'd10);
    run_ticks(1);
    $display("test_needy_social: state=%0d need_id=%0d", state, need_id);
    n_checks++; if (need_id !== 3'd5)   begin n_fail++; $display("FAIL needy_social_id: got %0d, required 5", need_id); end
  endtask

  task automatic test_sick_recover();
    apply_reset();
    set_stats(4'd0, 4'd0, 4'd12, 4'd0, 4'd10, 4'd0);
    run_ticks(2);
    $display("test_sick_pre: state=%0d alarms=%0d", state, alarm_cnt);
    n_checks++; if (state !== 3'd1)     begin n_fail++; $display("FAIL sick_pre_state: got %0d, required 1", state); end
    run_ticks(1);
    $display("test_sick_entry: state=%0d need_id=%0d alarm=%0b attention=%0b", state, need_id, alarm, attention);
    n_checks++; if (state !== 3'd3)     begin n_fail++; $display("FAIL sick_state: got %0d, required 3", state); end
    n_checks++; if (alarm !== 1'b1)     begin n_fail++; $display("FAIL sick_alarm: got %0b, required 1", alarm); end
    n_checks++; if (need_id !== 3'd2)   begin n_fail++; $display("FAIL sick_need_id: got %0d, required 2", need_id); end
    n_checks++; if (attention !== 1'b1) begin n_fail++; $display("FAIL sick_attention: got %0b, required 1", attention); end
    step();
    n_checks++; if (alarm !== 1'b0)     begin n_fail++; $display("FAIL sick_alarm_width: got %0b, required 0", alarm); end
    health = 4'd5;
    repeat (3) step();
    $display("test_sick_recover: state=%0d attention=%0b alarms=%0d", state, attention, alarm_cnt);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL recover_state: got %0d, required 0", state); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL recover_attention: got %0b, required 0", attention); end
    n_checks++; if (alarm_cnt !== 1)    begin n_fail++; $display("FAIL recover_alarm_count: got %0d, required 1", alarm_cnt); end
  endtask

  task automatic test_death_revive();
    apply_reset();
    set_stats(4'd0, 4'd0, 4'd15, 4'd0, 4'd10, 4'd0);
    run_ticks(6);
    n_checks++; if (state !== 3'd3)     begin n_fail++; $display("FAIL death_pre_state: got %0d, required 3", state); end
    run_ticks(1);
    $display("test_death: state=%0d alarms=%0d age=%0d need_id=%0d", state, alarm_cnt, age, need_id);
    n_checks++; if (state !== 3'd4)     begin n_fail++; $display("FAIL death_state: got %0d, required 4", state); end
    n_checks++; if (alarm_cnt !== 2)    begin n_fail++; $display("FAIL death_alarm_count: got %0d, required 2", alarm_cnt); end
    n_checks++; if (age !== 8'd7)       begin n_fail++; $display("FAIL death_age: got %0d, required 7", age); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL death_attention: got %0b, required 0", attention); end
    set_stats(4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0);
    run_ticks(3);
    $display("test_dead_frozen: state=%0d age=%0d need_id=%0d", state, age, need_id);
    n_checks++; if (state !== 3'd4)     begin n_fail++; $display("FAIL dead_frozen_state: got %0d, required 4", state); end
    n_checks++; if (age !== 8'd7)       begin n_fail++; $display("FAIL dead_frozen_age: got %0d, required 7", age); end
    n_checks++; if (need_id !== 3'd2)   begin n_fail++; $display("FAIL dead_frozen_need: got %0d, required 2", need_id); end
    revive = 1'b1;
    step();
    revive = 1'b0;
    $display("test_revive: state=%0d age=%0d need_id=%0d", state, age, need_id);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL revive_state: got %0d, required 0", state); end
    n_checks++; if (age !== 8'd0)       begin n_fail++; $display("FAIL revive_age: got %0d, required 0", age); end
    n_checks++; if (need_id !== 3'd7)   begin n_fail++; $display("FAIL revive_need: got %0d, required 7", need_id); end
    repeat (3) step();
    n_checks++; if (age !== 8'd1)       begin n_fail++; $display("FAIL revive_age_tick: got %0d, required 1", age); end
    revive = 1'b1;
    step();
    revive = 1'b0;
    $display("test_revive_ok: state=%0d age=%0d", state, age);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL revive_ok_state: got %0d, required 0", state); end
    n_checks++; if (age !== 8'd1)       begin n_fail++; $display("FAIL revive_ok_age: got %0d, required 1", age); end
  endtask

  task automatic test_sleepy_reset();
    apply_reset();
    set_stats(4'd0, 4'd0, 4'd0, 4'd9, 4'd2, 4'd0);
    run_ticks(1);
    $display("test_sleepy: state=%0d need_id=%0d attention=%0b", state, need_id, attention);
    n_checks++; if (state !== 3'd2)     begin n_fail++; $display("FAIL sleepy_state: got %0d, required 2", state); end
    n_checks++; if (need_id !== 3'd3)   begin n_fail++; $display("FAIL sleepy_need: got %0d, required 3", need_id); end
    n_checks++; if (attention !== 1'b0) begin n_fail++; $display("FAIL sleepy_attention: got %0b, required 0", attention); end
    repeat (2) step();
    reset = 1'b1;
    #1;
    $display("test_mid_reset: state=%0d need_id=%0d age=%0d", state, need_id, age);
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL midreset_state: got %0d, required 0", state); end
    n_checks++; if (need_id !== 3'd7)   begin n_fail++; $display("FAIL midreset_need: got %0d, required 7", need_id); end
    n_checks++; if (age !== 8'd0)       begin n_fail++; $display("FAIL midreset_age: got %0d, required 0", age); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    n_checks++; if (state !== 3'd0)     begin n_fail++; $display("FAIL early_tick_state: got %0d, required 0", state); end
    step();
    $display("test_first_tick: state=%0d age=%0d", state, age);
    n_checks++; if (state !== 3'd2)     begin n_fail++; $display("FAIL first_tick_state: got %0d, required 2", state); end
    n_checks++; if (age !== 8'd1)       begin n_fail++; $display("FAIL first_tick_age: got %0d, required 1", age); end
  endtask

  initial begin
    test_reset();
    test_ok_idle();
    test_needy_tie();
    test_sick_recover();
    test_death_revive();
    test_sleepy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
